alu_divseq: RTL and testbench
=============================

ALU_DIVSEQ -- requirements
Module: Alu_divseq

Parameters
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width (even, >= 4).
REQ-002 SHALL have parameter CNT_W, default log2(DATA_W)+1, iteration-counter width.

Interface
REQ-003 SHALL run on one clock; reset is asynchronous and active-low.
REQ-004 ctrl  input  Util_Control_T bundle  clock (Util_Control_Clock), then async active-low reset (Util_Control_Reset).
REQ-005 start  input  1  request a division; accepted only in IDLE or DONE.
REQ-006 signed_op  input  1  1 = two's-complement division (Divs), 0 = unsigned (Divu); sampled at accept.
REQ-007 flush  input  1  synchronous abort of any operation in progress.
REQ-008 dividend  input  DATA_W  numerator; sampled at accept.
REQ-009 divisor  input  DATA_W  denominator; sampled at accept.
REQ-010 busy  output  1  high in CALC and FIX.
REQ-011 done  output  1  one-cycle pulse; quotient/remainder valid in that cycle.
REQ-012 quotient  output  DATA_W  result for the LO register.
REQ-013 remainder  output  DATA_W  result for the HI register.
REQ-014 div_zero  output  1  divisor was zero for the last completed operation.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-016 IDLE/DONE + start=1 and divisor!=0: latch operand magnitudes, signs, signed_op; go to CALC with counter=DATA_W; clear div_zero.
REQ-017 IDLE/DONE + start=1 and divisor==0: go directly to DONE; quotient = all ones, remainder = dividend (unmodified), div_zero=1.
REQ-018 CALC: one radix-2 restoring step per cycle (shift partial remainder left by 1, bring in next dividend MSB, subtract divisor magnitude if no borrow, set quotient bit); counter decrements; after DATA_W steps go to FIX.
REQ-019 Subtraction SHALL use DATA_W+1 bits so an unsigned magnitude of 2^(DATA_W-1) (from signed MIN) is exact.
REQ-020 FIX: negate quotient iff signed_op and operand signs differ; negate remainder iff signed_op and dividend negative; go to DONE.
REQ-021 DONE: done=1 for exactly one cycle; without start, go to IDLE.
REQ-022 Latency: done SHALL assert DATA_W+2 cycles after the accepting edge (34 for DATA_W=32); 1 cycle for divide-by-zero.
REQ-023 quotient/remainder/div_zero SHALL hold from DONE until the next accepting edge; they SHALL NOT change during CALC/FIX.
REQ-024 start while busy SHALL be ignored (no queueing); start in DONE SHALL be accepted, giving back-to-back operation.
REQ-025 Signed MIN / -1 SHALL yield quotient = MIN, remainder = 0 (wrap, no exception).
REQ-026 flush=1 in any state SHALL force IDLE next edge, no done pulse, outputs held; flush has priority over start in the same cycle.
REQ-027 Operand inputs SHALL be ignored outside the accepting edge.

Reset
REQ-028 Reset low SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, counter=0, independent of the clock.
REQ-029 Reset asserted mid-CALC SHALL discard the operation; no done pulse after release.
REQ-030 First start SHALL be accepted on the first rising edge with reset deasserted.

Verification (DATA_W=32)
REQ-031 Unsigned 100 / 7, start one cycle -> busy for 33 cycles, done at edge 34, quotient=14, remainder=2, div_zero=0.
REQ-032 Signed 0xFFFFFFF9 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; same operands unsigned -> quotient=0x7FFFFFFC, remainder=1.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned -> quotient=0, remainder=0x80000000.
REQ-034 5 / 0 -> done one cycle after accept, quotient=0xFFFFFFFF, remainder=5, div_zero=1, busy never high.
REQ-035 Start, then flush on cycle 10 plus a start with new operands on cycle 12 -> no done for first op; second op's done at 34 cycles after cycle 12 with correct results.
REQ-036 Reset pulsed low mid-CALC, start in DONE of a prior op, and start while busy -> outputs zero asynchronously; back-to-back results correct; busy-time start has no effect.

Source files
------------

// File: rtl/alu_divseq.sv
// Sequential radix-2 restoring divider for DIV/DIVU.
// Quotient goes to LO and remainder goes to HI.
`timescale 1ns/1ps

package alu_divseq_pkg;
   typedef struct packed {
      logic clk;
      logic rst_n;
   } util_control_t;
endpackage

module alu_divseq
   import alu_divseq_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  util_control_t     ctrl,
   input  logic              start,
   input  logic              signed_op,
   input  logic              flush,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              div_zero
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   logic clk;
   logic rst_n;
   assign clk   = ctrl.clk;
   assign rst_n = ctrl.rst_n;

   state_t state_q, state_d;

   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] dvd_q;
   logic [DATA_W-1:0] dsr_q;
   logic              neg_q_q;
   logic              neg_r_q;
   logic [DATA_W-1:0] quo_q;
   logic [DATA_W-1:0] rmd_q;
   logic              dz_q;

   logic              idle_or_done;
   logic              accept;
   logic              zero_dsr;
   logic              a_neg;
   logic              b_neg;
   logic [DATA_W-1:0] a_mag;
   logic [DATA_W-1:0] b_mag;
   logic [DATA_W:0]   trial;
   logic [DATA_W:0]   diff;
   logic              fits;
   logic [DATA_W-1:0] new_rem;

   // Accept decode and operand magnitudes; MIN negates to 2^(W-1) unsigned.
   always_comb begin
      idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
      accept       = idle_or_done && start && !flush;
      zero_dsr     = (divisor == '0);
      a_neg        = signed_op & dividend[DATA_W-1];
      b_neg        = signed_op & divisor[DATA_W-1];
      a_mag        = a_neg ? -dividend : dividend;
      b_mag        = b_neg ? -divisor : divisor;
   end

   // One restoring step; the extra top bit of diff is the borrow.
   always_comb begin
      trial   = {rem_q, dvd_q[DATA_W-1]};
      diff    = trial - {1'b0, dsr_q};
      fits    = ~diff[DATA_W];
      new_rem = fits ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
   end

   // Next-state and status outputs; flush overrides everything.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start)
               state_d = zero_dsr ? S_DONE : S_CALC;
         end
         S_CALC: begin
            busy = 1'b1;
            if (cnt_q == CNT_W'(1))
               state_d = S_FIX;
         end
         S_FIX: begin
            busy    = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (start)
               state_d = zero_dsr ? S_DONE : S_CALC;
            else
               state_d = S_IDLE;
         end
      endcase
      if (flush)
         state_d = S_IDLE;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Working registers and held results; results move only on accept/FIX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dz_q    <= 1'b0;
      end else if (flush) begin
         cnt_q <= cnt_q;
      end else if (accept && zero_dsr) begin
         quo_q <= '1;
         rmd_q <= dividend;
         dz_q  <= 1'b1;
      end else if (accept) begin
         cnt_q   <= CNT_W'(DATA_W);
         rem_q   <= '0;
         dvd_q   <= a_mag;
         dsr_q   <= b_mag;
         neg_q_q <= a_neg ^ b_neg;
         neg_r_q <= a_neg;
         dz_q    <= 1'b0;
      end else if (state_q == S_CALC) begin
         cnt_q <= cnt_q - CNT_W'(1);
         rem_q <= new_rem;
         dvd_q <= {dvd_q[DATA_W-2:0], fits};
      end else if (state_q == S_FIX) begin
         quo_q <= neg_q_q ? -dvd_q : dvd_q;
         rmd_q <= neg_r_q ? -rem_q : rem_q;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rmd_q;
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_alu_divseq.sv
// Bench for alu_divseq: arithmetic reference model plus
// directed vectors with literal expectations.
`timescale 1ns/1ps

module tb_alu_divseq;
   import alu_divseq_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   util_control_t ctrl;
   logic          start = 1'b0;
   logic          signed_op = 1'b0;
   logic          flush = 1'b0;
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;
   logic          busy;
   logic          done;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_zero;

   assign ctrl.clk   = clk;
   assign ctrl.rst_n = rst_n;

   alu_divseq #(.DATA_W(W)) dut (
      .ctrl      (ctrl),
      .start     (start),
      .signed_op (signed_op),
      .flush     (flush),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act === exp)
         passes++;
      else
         $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference division from plain 64-bit arithmetic.
   function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic s);
      longint sa, sb, q, r;
      logic [63:0] qv, rv;
      if (b == '0)
         return {{W{1'b1}}, a};
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({{(64-W){1'b0}}, a});
         sb = longint'({{(64-W){1'b0}}, b});
      end
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      return {qv[W-1:0], rv[W-1:0]};
   endfunction

   // Model: an accepted op is busy W+1 cycles, then done for one.
   int           m_left;
   logic         m_done;
   logic [W-1:0] m_q, m_r, p_q, p_r;
   logic         m_dz;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_q    <= '0;
         m_r    <= '0;
         m_dz   <= 1'b0;
         p_q    <= '0;
         p_r    <= '0;
      end else if (flush) begin
         m_left <= 0;
         m_done <= 1'b0;
      end else if (start && m_left == 0) begin
         if (divisor == '0) begin
            m_q    <= '1;
            m_r    <= dividend;
            m_dz   <= 1'b1;
            m_done <= 1'b1;
         end else begin
            {p_q, p_r} <= ref_div(dividend, divisor, signed_op);
            m_dz   <= 1'b0;
            m_left <= W + 1;
            m_done <= 1'b0;
         end
      end else if (m_left == 1) begin
         m_left <= 0;
         m_done <= 1'b1;
         m_q    <= p_q;
         m_r    <= p_r;
      end else begin
         if (m_left > 0)
            m_left <= m_left - 1;
         m_done <= 1'b0;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("done", 64'(done), 64'(m_done));
      chk("quotient", 64'(quotient), 64'(m_q));
      chk("remainder", 64'(remainder), 64'(m_r));
      chk("div_zero", 64'(div_zero), 64'(m_dz));
   end

   int lat;
   int bcnt;

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
      start     = 1'b1;
      dividend  = a;
      divisor   = b;
      signed_op = s;
      @(posedge clk);
      #2;
      start     = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      signed_op = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(output int l, output int bc);
      l  = 0;
      bc = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (done) begin
            l = i;
            break;
         end
         if (busy)
            bc++;
      end
   endtask

   task automatic run(input string name, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic s,
                      input logic [W-1:0] eq, input logic [W-1:0] er,
                      input int elat);
      issue(a, b, s);
      wait_done(lat, bcnt);
      chk({name, " latency"}, 64'(lat), 64'(elat));
      chk({name, " busy cycles"}, 64'(bcnt), 64'(elat - 1));
      chk({name, " q"}, 64'(quotient), 64'(eq));
      chk({name, " r"}, 64'(remainder), 64'(er));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int seen;

   initial begin
      chk("pin 100/7", ref_div(32'd100, 32'd7, 1'b0), {32'd14, 32'd2});
      chk("pin s -7/2", ref_div(32'hFFFFFFF9, 32'd2, 1'b1),
          {32'hFFFFFFFD, 32'hFFFFFFFF});
      chk("pin s MIN/-1", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1),
          {32'h80000000, 32'h0});
      chk("pin 5/0", ref_div(32'd5, 32'd0, 1'b0), {32'hFFFFFFFF, 32'd5});

      #13;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst q", 64'(quotient), 64'd0);
      chk("rst r", 64'(remainder), 64'd0);
      chk("rst dz", 64'(div_zero), 64'd0);

      @(posedge clk);
      #2;
      rst_n = 1'b1;
      run("u 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34);
      chk("u 100/7 dz", 64'(div_zero), 64'd0);
      idle(2);
      run("s -7/2", 32'hFFFFFFF9, 32'd2, 1'b1,
          32'hFFFFFFFD, 32'hFFFFFFFF, 34);
      run("u -7/2", 32'hFFFFFFF9, 32'd2, 1'b0,
          32'h7FFFFFFC, 32'd1, 34);
      idle(1);
      run("s MIN/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1,
          32'h80000000, 32'd0, 34);
      run("u MIN/-1", 32'h80000000, 32'hFFFFFFFF, 1'b0,
          32'd0, 32'h80000000, 34);
      idle(1);
      run("5/0", 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1);
      chk("5/0 dz", 64'(div_zero), 64'd1);
      run("s -100/7", 32'hFFFFFF9C, 32'd7, 1'b1,
          32'hFFFFFFF2, 32'hFFFFFFFE, 34);
      run("s 100/-7", 32'd100, 32'hFFFFFFF9, 1'b1,
          32'hFFFFFFF2, 32'd2, 34);
      run("s -100/-7", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1,
          32'd14, 32'hFFFFFFFE, 34);

      // flush and start in the same DONE cycle: flush wins
      flush     = 1'b1;
      start     = 1'b1;
      dividend  = 32'd9;
      divisor   = 32'd0;
      @(posedge clk);
      #2;
      flush = 1'b0;
      start = 1'b0;
      chk("flush prio busy", 64'(busy), 64'd0);
      chk("flush prio done", 64'(done), 64'd0);
      chk("flush prio dz", 64'(div_zero), 64'd0);

      // flush mid-calculation, then a fresh op two cycles later
      idle(1);
      issue(32'd1000, 32'd3, 1'b0);
      repeat (9) @(posedge clk);
      #2;
      flush = 1'b1;
      @(posedge clk);
      #2;
      flush = 1'b0;
      chk("flush idle", 64'(busy), 64'd0);
      chk("flush held q", 64'(quotient), 64'd14);
      @(posedge clk);
      #2;
      run("after flush", 32'd12345, 32'd67, 1'b0, 32'd184, 32'd17, 34);

      // start while busy is ignored; start in DONE chains
      idle(2);
      issue(32'd1000000, 32'd999, 1'b0);
      idle(4);
      start    = 1'b1;
      dividend = 32'd7;
      divisor  = 32'd0;
      @(posedge clk);
      #2;
      start = 1'b0;
      wait_done(lat, bcnt);
      chk("busy start lat", 64'(lat), 64'd30);
      chk("busy start q", 64'(quotient), 64'd1001);
      chk("busy start r", 64'(remainder), 64'd1);
      chk("busy start dz", 64'(div_zero), 64'd0);
      run("b2b 77/5", 32'd77, 32'd5, 1'b0, 32'd15, 32'd2, 34);

      // asynchronous reset in the middle of a calculation
      idle(1);
      issue(32'd999, 32'd10, 1'b0);
      idle(8);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst busy", 64'(busy), 64'd0);
      chk("arst done", 64'(done), 64'd0);
      chk("arst q", 64'(quotient), 64'd0);
      chk("arst r", 64'(remainder), 64'd0);
      chk("arst dz", 64'(div_zero), 64'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done)
            seen++;
      end
      chk("no done after reset", 64'(seen), 64'd0);
      run("s 50/7", 32'd50, 32'd7, 1'b1, 32'd7, 32'd1, 34);
      idle(2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
